riscv_imem_dual_arb: RTL and testbench
======================================

Name: riscv_imem_dual_arb

Overview:
- Merges the core's two instruction-fetch request ports (imemreq0/imemreq1) onto one memory request port.
- Routes the in-order memory responses back to the port that issued each request.
- Sits between the dual-fetch core and the single-ported instruction memory.
- Round-robin arbitration; an in-order tag FIFO records the port ID of every outstanding request.

Parameters:
- REQ_SZ, 67, request message width (VC_MEM_REQ_MSG_SZ(32,32)).
- RESP_SZ, 35, response message width (VC_MEM_RESP_MSG_SZ(32)).
- DEPTH, 4, maximum outstanding requests; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imemreq0_msg  in  REQ_SZ  request from fetch port 0.
- imemreq0_val  in  1  port 0 request valid.
- imemreq0_rdy  out  1  port 0 request accepted this cycle.
- imemreq1_msg  in  REQ_SZ  request from fetch port 1.
- imemreq1_val  in  1  port 1 request valid.
- imemreq1_rdy  out  1  port 1 request accepted this cycle.
- memreq_msg  out  REQ_SZ  request to memory.
- memreq_val  out  1  memory request valid.
- memreq_rdy  in  1  memory accepts request.
- memresp_msg  in  RESP_SZ  memory response; in order, no backpressure.
- memresp_val  in  1  memory response valid.
- imemresp0_msg  out  RESP_SZ  response to port 0.
- imemresp0_val  out  1  response valid, port 0.
- imemresp1_msg  out  RESP_SZ  response to port 1.
- imemresp1_val  out  1  response valid, port 1.

Behaviour:
- State:
  - prio (1b): port favoured on conflict.
  - Tag FIFO: DEPTH x 1b, with wr_ptr, rd_ptr, count (log2(DEPTH)+1 bits).
- Reset (reset==0, async): prio=0, pointers=0, count=0. All val/rdy outputs held 0 while reset is low.
- full = (count==DEPTH); empty = (count==0); both derived from registered count only.
- Grant (combinational):
  - Only one port valid: that port.
  - Both valid: port==prio.
  - Neither valid: no grant.
- Request outputs:
  - memreq_val = (imemreq0_val | imemreq1_val) & !full.
  - memreq_msg = granted port's msg; port 0 msg when idle.
- imemreqN_rdy = grant==N & memreq_rdy & !full. A non-granted port sees rdy=0 and must hold its msg/val.
- Fire = memreq_val & memreq_rdy:
  - Push grant ID at wr_ptr.
  - If both ports were valid, prio <= !grant. Otherwise prio is unchanged.
- Request path latency: 0 cycles (combinational pass-through).
- Response (memresp_val):
  - Read head ID, pop the FIFO.
  - imemresp<ID>_val=1 in the same cycle; the other port's val=0.
  - Both imemresp*_msg = memresp_msg at all times.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with pop in the same cycle: no push that cycle (full uses registered count). Push resumes next cycle.
- Pointers wrap modulo DEPTH.
- memresp_val while empty:
  - Response dropped; both resp vals 0; no state change.
  - Simulation-only $display error under `ifndef SYNTHESIS.
- Reset mid-operation: outstanding tags discarded. Late responses after release fall under the empty-FIFO rule.

Optional Feature:
- Macro RISCV_IMEM_ARB_STATS_EN.
- When defined, adds four 32-bit wrapping counters, cleared by reset, each with an output port:
  - stat_grant0: increments on port-0 fire.
  - stat_grant1: increments on port-1 fire.
  - stat_conflict: increments in cycles where both ports are valid and one fires.
  - stat_full: increments in cycles where any port is valid and full==1.
- When undefined: no counters and no stat_* ports. Remaining behaviour is identical.

Decomposition:
- Shared package/header:
  - Port-ID constants (PORT0=1'b0, PORT1=1'b1).
  - Message-width defines (reused VC_MEM_* macros).
  - Default DEPTH.
- One sub-module, riscv_imem_dual_arb_tag_fifo: parameterised 1-bit-wide synchronous FIFO with push/pop/full/empty/head and async active-low reset.
- Arbiter logic and stats stay in the top module.

Test Plan:
- Port 0 only, addr 0x00001000, memreq_rdy=1 -> memreq_msg==imemreq0_msg and imemreq0_rdy=1 same cycle. Response data 0xDEADBEEF two cycles later -> imemresp0_val=1, imemresp1_val=0, data 0xDEADBEEF.
- Both ports valid from first cycle after reset (addrs 0x100, 0x104) -> port 0 granted cycle 1, port 1 cycle 2 (prio=1 then 0). Responses 0xA, 0xB -> 0xA on resp0, 0xB on resp1.
- Both ports valid, memreq_rdy=0 for 3 cycles -> both rdy=0, count stays 0, prio stays 0. Grant to port 0 on cycle 4.
- DEPTH=4, five port-1 requests, no responses -> 4 accepted, 5th sees rdy=0 and memreq_val=0. One response (count 4->3) -> 5th accepted next cycle.
- memresp_val with count=0 -> both imemresp*_val=0, count stays 0, error message printed.
- Two outstanding, reset pulsed low for 1 cycle -> count=0 after release. Both late responses dropped. New port-0 request then routes correctly.

Source files
------------

// File: rtl/riscv_imem_dual_arb_pkg.sv
// riscv_imem_dual_arb_pkg: port IDs, message widths and default depth shared by the dual-fetch arbiter.
`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a, d) (1 + (a) + $clog2((d) / 8) + (d))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d) (1 + $clog2((d) / 8) + (d))
`endif

package riscv_imem_dual_arb_pkg;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int REQ_SZ_DEFAULT = `VC_MEM_REQ_MSG_SZ(32, 32);
  localparam int RESP_SZ_DEFAULT = `VC_MEM_RESP_MSG_SZ(32);
  localparam int DEPTH_DEFAULT = 4;
endpackage

// File: rtl/riscv_imem_dual_arb_tag_fifo.sv
// riscv_imem_dual_arb_tag_fifo: in-order 1-bit port-ID FIFO for outstanding fetch requests.
module riscv_imem_dual_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
  // Tag storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
endmodule

// File: rtl/riscv_imem_dual_arb.sv
// riscv_imem_dual_arb: round-robin merge of two fetch ports onto one memory port, in-order response routing.
// Optional counters enabled by RISCV_IMEM_ARB_STATS_EN.
module riscv_imem_dual_arb
  import riscv_imem_dual_arb_pkg::*;
#(
  parameter int REQ_SZ = REQ_SZ_DEFAULT,
  parameter int RESP_SZ = RESP_SZ_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_SZ-1:0]  imemreq0_msg,
  input  logic               imemreq0_val,
  output logic               imemreq0_rdy,
  input  logic [REQ_SZ-1:0]  imemreq1_msg,
  input  logic               imemreq1_val,
  output logic               imemreq1_rdy,
  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,
  output logic [RESP_SZ-1:0] imemresp0_msg,
  output logic               imemresp0_val,
  output logic [RESP_SZ-1:0] imemresp1_msg,
  output logic               imemresp1_val
`ifdef RISCV_IMEM_ARB_STATS_EN
  ,
  output logic [31:0]        stat_grant0,
  output logic [31:0]        stat_grant1,
  output logic [31:0]        stat_conflict,
  output logic [31:0]        stat_full
`endif
);
  logic prio, grant, any_val, both_val, fire, pop, full, empty, head;
  always_comb begin
    any_val = imemreq0_val | imemreq1_val;
    both_val = imemreq0_val & imemreq1_val;
    grant = both_val ? prio : (imemreq1_val ? PORT1 : PORT0);
    memreq_val = reset & any_val & !full;
    memreq_msg = (grant == PORT1) ? imemreq1_msg : imemreq0_msg;
    imemreq0_rdy = memreq_val & memreq_rdy & imemreq0_val & (grant == PORT0);
    imemreq1_rdy = memreq_val & memreq_rdy & imemreq1_val & (grant == PORT1);
    fire = memreq_val & memreq_rdy;
    pop = reset & memresp_val & !empty;
    imemresp0_val = pop & (head == PORT0);
    imemresp1_val = pop & (head == PORT1);
  end
  assign imemresp0_msg = memresp_msg;
  assign imemresp1_msg = memresp_msg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio <= PORT0;
    else if (fire && both_val) prio <= !grant;
  end
  riscv_imem_dual_arb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk(clk),
    .reset(reset),
    .push(fire),
    .pop(pop),
    .din(grant),
    .full(full),
    .empty(empty),
    .head(head)
  );
`ifdef RISCV_IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_conflict <= '0;
      stat_full <= '0;
    end else begin
      if (fire && grant == PORT0) stat_grant0 <= stat_grant0 + 1'b1;
      if (fire && grant == PORT1) stat_grant1 <= stat_grant1 + 1'b1;
      if (fire && both_val) stat_conflict <= stat_conflict + 1'b1;
      if (any_val && full) stat_full <= stat_full + 1'b1;
    end
  end
`endif
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && memresp_val && empty) $display("riscv_imem_dual_arb: error: memory response with no outstanding request dropped");
  end
`endif
endmodule

// File: tb/tb_riscv_imem_dual_arb.sv
// tb_riscv_imem_dual_arb: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_riscv_imem_dual_arb;
  localparam int REQ_SZ = 67;
  localparam int RESP_SZ = 35;
  logic clk = 1'b0, reset = 1'b0;
  logic [REQ_SZ-1:0] imemreq0_msg = '0, imemreq1_msg = '0, memreq_msg;
  logic imemreq0_val = 1'b0, imemreq1_val = 1'b0, memreq_rdy = 1'b0, memresp_val = 1'b0;
  logic imemreq0_rdy, imemreq1_rdy, memreq_val, imemresp0_val, imemresp1_val;
  logic [RESP_SZ-1:0] memresp_msg = '0, imemresp0_msg, imemresp1_msg;
  int total = 0, bad = 0;
  logic [RESP_SZ:0] sb[$];

  riscv_imem_dual_arb dut (
    .clk(clk), .reset(reset),
    .imemreq0_msg(imemreq0_msg), .imemreq0_val(imemreq0_val), .imemreq0_rdy(imemreq0_rdy),
    .imemreq1_msg(imemreq1_msg), .imemreq1_val(imemreq1_val), .imemreq1_rdy(imemreq1_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .imemresp0_msg(imemresp0_msg), .imemresp0_val(imemresp0_val),
    .imemresp1_msg(imemresp1_msg), .imemresp1_val(imemresp1_val)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_SZ-1:0] rq(input logic [31:0] a);
    return {1'b0, a, 2'b00, 32'h0};
  endfunction

  task automatic chk(input string n, input logic [REQ_SZ-1:0] act, input logic [REQ_SZ-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic resp(input logic p, input logic [31:0] d);
    memresp_val = 1'b1;
    memresp_msg = {3'b000, d};
    sb.push_back({p, 3'b000, d});
  endtask

  task automatic resp_drop(input logic [31:0] d);
    memresp_val = 1'b1;
    memresp_msg = {3'b000, d};
  endtask

  always @(negedge clk) begin
    if (imemresp0_val || imemresp1_val) begin
      logic [RESP_SZ:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got val0=%b val1=%b msg=%h want no response", imemresp0_val, imemresp1_val, imemresp0_msg);
      end else begin
        e = sb.pop_front();
        if ({imemresp1_val, imemresp0_val} !== (e[RESP_SZ] ? 2'b10 : 2'b01) || imemresp0_msg !== e[RESP_SZ-1:0] || imemresp1_msg !== e[RESP_SZ-1:0]) begin
          bad++;
          $display("FAIL resp_route: got val1val0=%b msg0=%h msg1=%h want port%0d msg=%h", {imemresp1_val, imemresp0_val}, imemresp0_msg, imemresp1_msg, e[RESP_SZ], e[RESP_SZ-1:0]);
        end
      end
    end
  end

  initial begin
    imemreq0_val = 1'b1;
    imemreq1_val = 1'b1;
    memreq_rdy = 1'b1;
    memresp_val = 1'b1;
    look();
    chk("rst_memreq_val", memreq_val, 1'b0);
    chk("rst_rdy0", imemreq0_rdy, 1'b0);
    chk("rst_rdy1", imemreq1_rdy, 1'b0);
    step();
    reset = 1'b1;
    {imemreq0_val, imemreq1_val, memresp_val} = '0;
    step();
    // single port 0 request, response two cycles after acceptance
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h0000_1000);
    look();
    chk("t1_val", memreq_val, 1'b1);
    chk("t1_msg", memreq_msg, rq(32'h0000_1000));
    chk("t1_rdy0", imemreq0_rdy, 1'b1);
    chk("t1_rdy1", imemreq1_rdy, 1'b0);
    step();
    imemreq0_val = 1'b0;
    step();
    resp(1'b0, 32'hDEAD_BEEF);
    step();
    memresp_val = 1'b0;
    // both valid: port 0 first, then port 1, with push and pop together on cycle 3
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h100);
    imemreq1_val = 1'b1;
    imemreq1_msg = rq(32'h104);
    look();
    chk("t2_c1_rdy0", imemreq0_rdy, 1'b1);
    chk("t2_c1_rdy1", imemreq1_rdy, 1'b0);
    chk("t2_c1_msg", memreq_msg, rq(32'h100));
    step();
    imemreq0_msg = rq(32'h108);
    look();
    chk("t2_c2_rdy0", imemreq0_rdy, 1'b0);
    chk("t2_c2_rdy1", imemreq1_rdy, 1'b1);
    chk("t2_c2_msg", memreq_msg, rq(32'h104));
    step();
    imemreq1_val = 1'b0;
    resp(1'b0, 32'hA);
    look();
    chk("t2_c3_rdy0", imemreq0_rdy, 1'b1);
    step();
    imemreq0_val = 1'b0;
    resp(1'b1, 32'hB);
    step();
    resp(1'b0, 32'hC);
    step();
    memresp_val = 1'b0;
    // memory stalls for three cycles, priority must not move
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h200);
    imemreq1_val = 1'b1;
    imemreq1_msg = rq(32'h204);
    memreq_rdy = 1'b0;
    repeat (3) begin
      look();
      chk("t3_stall_rdy0", imemreq0_rdy, 1'b0);
      chk("t3_stall_rdy1", imemreq1_rdy, 1'b0);
      chk("t3_stall_val", memreq_val, 1'b1);
      step();
    end
    memreq_rdy = 1'b1;
    look();
    chk("t3_grant_rdy0", imemreq0_rdy, 1'b1);
    chk("t3_grant_rdy1", imemreq1_rdy, 1'b0);
    chk("t3_grant_msg", memreq_msg, rq(32'h200));
    step();
    {imemreq0_val, imemreq1_val} = '0;
    step();
    resp(1'b0, 32'hD);
    step();
    memresp_val = 1'b0;
    // fill the tag FIFO from port 1
    imemreq1_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imemreq1_msg = rq(32'h300 + 32'(4 * i));
      look();
      chk("t4_accept_rdy1", imemreq1_rdy, 1'b1);
      step();
    end
    imemreq1_msg = rq(32'h310);
    look();
    chk("t4_full_rdy1", imemreq1_rdy, 1'b0);
    chk("t4_full_val", memreq_val, 1'b0);
    step();
    resp(1'b1, 32'h11);
    look();
    chk("t4_popcycle_rdy1", imemreq1_rdy, 1'b0);
    step();
    memresp_val = 1'b0;
    look();
    chk("t4_resume_rdy1", imemreq1_rdy, 1'b1);
    chk("t4_resume_msg", memreq_msg, rq(32'h310));
    step();
    imemreq1_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp(1'b1, 32'h12 + 32'(i));
      step();
    end
    memresp_val = 1'b0;
    // response with nothing outstanding is dropped
    resp_drop(32'h99);
    look();
    chk("t5_drop_val0", imemresp0_val, 1'b0);
    chk("t5_drop_val1", imemresp1_val, 1'b0);
    step();
    memresp_val = 1'b0;
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h400);
    look();
    chk("t5_after_rdy0", imemreq0_rdy, 1'b1);
    step();
    imemreq0_val = 1'b0;
    resp(1'b0, 32'h55);
    step();
    memresp_val = 1'b0;
    // reset with two tags outstanding
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h500);
    step();
    imemreq0_val = 1'b0;
    imemreq1_val = 1'b1;
    imemreq1_msg = rq(32'h504);
    step();
    imemreq1_val = 1'b0;
    imemreq0_val = 1'b1;
    reset = 1'b0;
    look();
    chk("t6_rst_val", memreq_val, 1'b0);
    chk("t6_rst_rdy0", imemreq0_rdy, 1'b0);
    step();
    reset = 1'b1;
    imemreq0_val = 1'b0;
    step();
    resp_drop(32'hE1);
    look();
    chk("t6_late1_val", {imemresp1_val, imemresp0_val}, 2'b00);
    step();
    resp_drop(32'hE2);
    look();
    chk("t6_late2_val", {imemresp1_val, imemresp0_val}, 2'b00);
    step();
    memresp_val = 1'b0;
    imemreq0_val = 1'b1;
    imemreq0_msg = rq(32'h600);
    look();
    chk("t6_new_rdy0", imemreq0_rdy, 1'b1);
    step();
    imemreq0_val = 1'b0;
    resp(1'b0, 32'h66);
    step();
    memresp_val = 1'b0;
    step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending responses want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
